dtt_xbar_ingress_queue: RTL and testbench
=========================================

// Module: dtt_xbar_ingress_queue
// PURPOSE
//   Per-input ingress buffer that sits directly upstream of one dtt_crossbar_switch input port.
//   - Accepts {data, dest} words from a source over a valid/ready handshake.
//   - Holds them in a DEPTH-entry FIFO and presents the head word to the crossbar as x_data/x_dest/x_valid.
//   - The crossbar-side arbiter pops the head with x_grant.
//   - Screens out-of-range destinations and flags a head word that is stuck without a grant.
// PARAMETERS
//   N_OUT       4    number of crossbar outputs; x_dest width matches the crossbar in_dest port (N_OUT bits)
//   DATA_WIDTH  32   payload width
//   DEPTH       8    FIFO entries; power of 2, >= 2
//   STALL_LIMIT 16   cycles a head word may wait ungranted before stall is set; >= 1
// PORTS
//   clk        in   1                   rising-edge clock
//   rst        in   1                   synchronous reset, active-high
//   s_data     in   DATA_WIDTH          source payload
//   s_dest     in   N_OUT               destination, binary output index
//   s_valid    in   1                   source word valid
//   s_ready    out  1                   queue can accept
//   x_data     out  DATA_WIDTH          head payload to crossbar in_data
//   x_dest     out  N_OUT               head destination to crossbar in_dest
//   x_valid    out  1                   head valid to crossbar in_valid
//   x_grant    in   1                   crossbar consumes head this cycle
//   level      out  $clog2(DEPTH)+1     current occupancy, 0..DEPTH
//   err_dest   out  1                   1-cycle pulse: a word with s_dest >= N_OUT was discarded
//   stall      out  1                   head waited STALL_LIMIT cycles without grant
// BEHAVIOUR
//   Reset (rst=1 at a clk edge)
//   - Clears wr_ptr, rd_ptr, level, stall_cnt, stall and err_dest to 0.
//   - s_ready=0 and x_valid=0 during reset; x_data/x_dest are don't-care while x_valid=0.
//   - Applying reset mid-stream discards all queued words; no partial output follows.
//   Handshakes
//   - Push when s_valid & s_ready. Pop when x_valid & x_grant.
//   - s_ready = !rst & (level != DEPTH). It is combinational from registered state.
//   - There is no same-cycle bypass: a full queue deasserts s_ready even when a pop happens in that cycle.
//   - x_grant while x_valid=0 is ignored.
//   - x_data/x_dest must hold stable while x_valid=1 & x_grant=0.
//   Latency
//   - A word pushed at edge N into an empty queue is presented with x_valid=1 after edge N, i.e. in cycle N+1.
//   - Throughput is 1 word/cycle; simultaneous push and pop keep level unchanged.
//   - A pop at edge N shows the next entry, or x_valid=0, in cycle N+1.
//   Destination screen
//   - A pushed word with s_dest >= N_OUT completes the handshake but is not written.
//   - err_dest=1 in the following cycle; level does not change.
//   Pointers and level
//   - wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - level = level + push_wr - pop.
//   - level saturates in neither direction by construction.
//   Stall FSM (states WAIT, STALLED)
//   - WAIT: stall_cnt increments each cycle x_valid & !x_grant.
//     - When stall_cnt reaches STALL_LIMIT-1: -> STALLED, stall=1.
//   - STALLED: stall stays 1 until a pop -> WAIT.
//   - Any pop, or x_valid=0, clears stall_cnt.
//   - A pop and a timeout in the same cycle: the pop wins and stall stays 0.
// CONFIGURATION
//   DTT_INGRESS_STATS_EN defined
//   - Adds ports acc_cnt (out, 16) and drop_cnt (out, 16).
//   - Both are saturating counters of words written and words discarded by the destination screen.
//   - Both reset to 0 and stick at 16'hFFFF.
//   DTT_INGRESS_STATS_EN undefined
//   - The ports and logic are absent; all other behaviour is identical.
// TESTING
//   - Reset: hold rst=1 for 2 clk -> s_ready=0, x_valid=0, level=0, stall=0, err_dest=0; after release s_ready=1.
//   - Pass-through: push 32'hAAAA_BBBB dest=2 with x_grant=1 -> x_valid=1, x_data=AAAA_BBBB, x_dest=2 one cycle later; level returns to 0.
//   - Fill/drain with x_grant=0:
//     - Push 8 words 0..7 -> level=8, s_ready=0, and a 9th push is not accepted.
//     - Grant 8 cycles -> words 0..7 appear in order, then x_valid=0, with pointers wrapped.
//   - Bad destination: push dest=5 with N_OUT=4 -> err_dest=1 for one cycle, level unchanged, nothing emitted (drop_cnt=1 with STATS_EN).
//   - Stall: one word queued and x_grant=0 for 16 cycles -> stall=1; grant once -> stall=0 the next cycle.
//   - Mid-stream reset: level=5, assert rst for 1 cycle -> level=0, x_valid=0; the next pushed word 32'h1111_2222 is emitted first.

Source files
------------

// File: rtl/dtt_xbar_ingress_queue.sv
// Ingress FIFO feeding one crossbar input: screens destinations, presents the head word, flags stalled heads.
// Optional saturating statistics counters (acc_cnt, drop_cnt) are enabled by defining DTT_INGRESS_STATS_EN.
module dtt_xbar_ingress_queue #(
   parameter int N_OUT       = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 8,
   parameter int STALL_LIMIT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    s_data,
   input  logic [N_OUT-1:0]         s_dest,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [DATA_WIDTH-1:0]    x_data,
   output logic [N_OUT-1:0]         x_dest,
   output logic                     x_valid,
   input  logic                     x_grant,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     err_dest,
   output logic                     stall,
   output logic                     dbg_stall_state
`ifdef DTT_INGRESS_STATS_EN
   ,
   output logic [15:0]              acc_cnt,
   output logic [15:0]              drop_cnt
`endif
);

   localparam int PW  = $clog2(DEPTH);
   localparam int LW  = PW + 1;
   localparam int SCW = $clog2(STALL_LIMIT) + 1;
   localparam int EW  = DATA_WIDTH + N_OUT;
   localparam logic [LW-1:0]  FULL_LVL   = LW'(DEPTH);
   localparam logic [SCW-1:0] CNT_LAST   = SCW'(STALL_LIMIT - 1);
   localparam logic [31:0]    N_OUT_U    = 32'(N_OUT);

   typedef enum logic {
      ST_WAIT    = 1'b0,
      ST_STALLED = 1'b1
   } stall_state_e;

   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [SCW-1:0]   stall_cnt_q, stall_cnt_d;
   stall_state_e     state_q, state_d;
   logic             err_dest_q, err_dest_d;

   logic             push, push_wr, push_bad, pop, dest_ok;

   // Handshakes: a transfer happens on a cycle where valid and ready are both high;
   // ready never depends on valid, and a full queue stays not-ready even while popping.
   assign s_ready  = !rst && (level_q != FULL_LVL);
   assign x_valid  = !rst && (level_q != '0);
   assign {x_dest, x_data} = mem_q[rd_ptr_q];

   assign dest_ok  = 32'(s_dest) < N_OUT_U;
   assign push     = s_valid && s_ready;
   assign push_wr  = push && dest_ok;
   assign push_bad = push && !dest_ok;
   assign pop      = x_valid && x_grant;

   assign level           = level_q;
   assign err_dest        = err_dest_q;
   assign stall           = (state_q == ST_STALLED);
   assign dbg_stall_state = state_q;

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      err_dest_d = push_bad;
      if (push_wr) begin
         mem_d[wr_ptr_q] = {s_dest, s_data};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push_wr, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // A pop (or an empty head) always resets the wait, so a grant in the timeout cycle keeps stall low.
   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      if (pop || !x_valid) begin
         state_d     = ST_WAIT;
         stall_cnt_d = '0;
      end else begin
         unique case (state_q)
            ST_WAIT: begin
               if (stall_cnt_q == CNT_LAST) begin
                  state_d = ST_STALLED;
               end else begin
                  stall_cnt_d = stall_cnt_q + SCW'(1);
               end
            end
            ST_STALLED: state_d = ST_STALLED;
            default:    state_d = ST_WAIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         stall_cnt_q <= '0;
         state_q     <= ST_WAIT;
         err_dest_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         stall_cnt_q <= stall_cnt_d;
         state_q     <= state_d;
         err_dest_q  <= err_dest_d;
      end
   end

`ifdef DTT_INGRESS_STATS_EN
   logic [15:0] acc_cnt_q, acc_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      acc_cnt_d  = acc_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (push_wr && (acc_cnt_q != 16'hFFFF)) begin
         acc_cnt_d = acc_cnt_q + 16'd1;
      end
      if (push_bad && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         acc_cnt_q  <= acc_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign acc_cnt  = acc_cnt_q;
   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dtt_xbar_ingress_queue.sv
// Directed bench for dtt_xbar_ingress_queue: vector table plus hand sequences for fill/drain, stall and reset.
module tb_dtt_xbar_ingress_queue;

   logic        clk;
   logic        rst;
   logic [31:0] s_data;
   logic [3:0]  s_dest;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] x_data;
   logic [3:0]  x_dest;
   logic        x_valid;
   logic        x_grant;
   logic [3:0]  level;
   logic        err_dest;
   logic        stall;
   logic        dbg_stall_state;
`ifdef DTT_INGRESS_STATS_EN
   logic [15:0] acc_cnt;
   logic [15:0] drop_cnt;
`endif

   int n_total = 0;
   int n_pass  = 0;

   dtt_xbar_ingress_queue #(
      .N_OUT(4), .DATA_WIDTH(32), .DEPTH(8), .STALL_LIMIT(16)
   ) dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_dest(s_dest), .s_valid(s_valid), .s_ready(s_ready),
      .x_data(x_data), .x_dest(x_dest), .x_valid(x_valid), .x_grant(x_grant),
      .level(level), .err_dest(err_dest), .stall(stall),
      .dbg_stall_state(dbg_stall_state)
`ifdef DTT_INGRESS_STATS_EN
      , .acc_cnt(acc_cnt), .drop_cnt(drop_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        sv;
      logic [31:0] sd;
      logic [3:0]  sdst;
      logic        gr;
      logic        e_rdy;
      logic        e_xv;
      logic [31:0] e_xd;
      logic [3:0]  e_xdst;
      logic [3:0]  e_lvl;
      logic        e_err;
      logic        e_stall;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_dest = '0; x_grant = 1'b0;

      // vector rows: inputs for the cycle, expected outputs seen in that cycle before the edge
      tbl[0]  = '{1'b1, 32'hAAAA_BBBB, 4'd2, 1'b1, 1'b1, 1'b0, 32'h0,         4'd0, 4'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 32'h0,         4'd0, 1'b1, 1'b1, 1'b1, 32'hAAAA_BBBB, 4'd2, 4'd1, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 32'h0,         4'd0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 4'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 32'h5,         4'd5, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 4'd0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 32'h0,         4'd0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 4'd0, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 32'h0,         4'd0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 4'd0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 32'h10,        4'd1, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 4'd0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 32'h20,        4'd3, 1'b1, 1'b1, 1'b1, 32'h10,        4'd1, 4'd1, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 32'h0,         4'd0, 1'b0, 1'b1, 1'b1, 32'h20,        4'd3, 4'd1, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 32'h0,         4'd0, 1'b1, 1'b1, 1'b1, 32'h20,        4'd3, 4'd1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 32'h0,         4'd0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 4'd0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 32'h44,        4'd4, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 4'd0, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 32'h0,         4'd0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 4'd0, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 32'h0,         4'd0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0, 4'd0, 1'b0, 1'b0};

      // reset held for two edges
      tick();
      tick();
      chk("rst_s_ready", s_ready, 0);
      chk("rst_x_valid", x_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_stall", stall, 0);
      chk("rst_err_dest", err_dest, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_s_ready", s_ready, 1);

      for (int i = 0; i < 14; i++) begin
         s_valid = tbl[i].sv; s_data = tbl[i].sd; s_dest = tbl[i].sdst; x_grant = tbl[i].gr;
         #1;
         chk($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].e_rdy);
         chk($sformatf("vec%0d_x_valid", i), x_valid, tbl[i].e_xv);
         if (tbl[i].e_xv) begin
            chk($sformatf("vec%0d_x_data", i), x_data, tbl[i].e_xd);
            chk($sformatf("vec%0d_x_dest", i), x_dest, tbl[i].e_xdst);
         end
         chk($sformatf("vec%0d_level", i), level, tbl[i].e_lvl);
         chk($sformatf("vec%0d_err_dest", i), err_dest, tbl[i].e_err);
         chk($sformatf("vec%0d_stall", i), stall, tbl[i].e_stall);
         tick();
      end
      s_valid = 1'b0; x_grant = 1'b0;
`ifdef DTT_INGRESS_STATS_EN
      #1;
      chk("stats_acc_cnt", acc_cnt, 3);
      chk("stats_drop_cnt", drop_cnt, 2);
`endif

      // fill with no grants
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1; s_data = 32'(i); s_dest = 4'(i % 4);
         #1;
         chk($sformatf("fill%0d_s_ready", i), s_ready, 1);
         tick();
      end
      s_valid = 1'b0;
      #1;
      chk("full_level", level, 8);
      chk("full_s_ready", s_ready, 0);
      chk("full_head", x_data, 0);
      s_valid = 1'b1; s_data = 32'd99; s_dest = 4'd1;
      tick();
      s_valid = 1'b0;
      #1;
      chk("ninth_push_level", level, 8);

      // drain in order; a push offered during the first pop must be refused
      for (int i = 0; i < 8; i++) begin
         x_grant = 1'b1;
         if (i == 0) begin
            s_valid = 1'b1; s_data = 32'hDEAD; s_dest = 4'd0;
         end
         #1;
         chk($sformatf("drain%0d_x_valid", i), x_valid, 1);
         chk($sformatf("drain%0d_x_data", i), x_data, 32'(i));
         chk($sformatf("drain%0d_x_dest", i), x_dest, 4'(i % 4));
         if (i == 0) chk("no_bypass_s_ready", s_ready, 0);
         tick();
         s_valid = 1'b0;
         if (i == 0) begin
            #1;
            chk("no_bypass_level", level, 7);
         end
      end
      x_grant = 1'b0;
      #1;
      chk("drained_x_valid", x_valid, 0);
      chk("drained_level", level, 0);

      // pointers have wrapped; a new word still comes out intact
      s_valid = 1'b1; s_data = 32'h77; s_dest = 4'd1;
      tick();
      s_valid = 1'b0;
      #1;
      chk("wrap_x_valid", x_valid, 1);
      chk("wrap_x_data", x_data, 32'h77);
      x_grant = 1'b1;
      tick();
      x_grant = 1'b0;

      // stall after 16 ungranted cycles, cleared by a grant
      s_valid = 1'b1; s_data = 32'h55; s_dest = 4'd2;
      tick();
      s_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #1;
         chk($sformatf("wait%0d_stall", k), stall, 0);
         tick();
      end
      chk("stall_set", stall, 1);
      chk("stall_dbg_state", dbg_stall_state, 1);
      chk("stall_x_valid", x_valid, 1);
      x_grant = 1'b1;
      #1;
      chk("stall_held_until_pop", stall, 1);
      tick();
      x_grant = 1'b0;
      #1;
      chk("stall_cleared", stall, 0);
      chk("stall_dbg_cleared", dbg_stall_state, 0);
      chk("stall_x_valid_after", x_valid, 0);

      // grant in the would-be timeout cycle: pop wins
      s_valid = 1'b1; s_data = 32'h66; s_dest = 4'd0;
      tick();
      s_valid = 1'b0;
      repeat (15) tick();
      x_grant = 1'b1;
      #1;
      chk("race_stall_before", stall, 0);
      tick();
      x_grant = 1'b0;
      #1;
      chk("race_stall_after", stall, 0);
      chk("race_x_valid", x_valid, 0);

      // mid-stream reset
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1; s_data = 32'h100 + 32'(i); s_dest = 4'd3;
         tick();
      end
      s_valid = 1'b0;
      #1;
      chk("mid_level5", level, 5);
      rst = 1'b1;
      #1;
      chk("mid_rst_s_ready", s_ready, 0);
      chk("mid_rst_x_valid", x_valid, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("mid_after_level", level, 0);
      chk("mid_after_x_valid", x_valid, 0);
      chk("mid_after_s_ready", s_ready, 1);
      s_valid = 1'b1; s_data = 32'h1111_2222; s_dest = 4'd0;
      tick();
      s_valid = 1'b0;
      #1;
      chk("mid_first_x_valid", x_valid, 1);
      chk("mid_first_x_data", x_data, 32'h1111_2222);
      chk("mid_first_level", level, 1);
      x_grant = 1'b1;
      tick();
      x_grant = 1'b0;
      #1;
      chk("mid_final_level", level, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
